// File: rtl/if_fetch_unit.sv
// if_fetch_unit
//
// Instruction fetch front end. It issues sequential 64-bit-aligned fetch
// requests to instruction memory and keeps a small prefetch queue of returned
// words. The queue head is presented to the IF/ID register.
//
// The unit uses credit-based flow control. A request is issued only when its
// response is guaranteed a queue slot: pending + queue_count < DEPTH.
//
// A redirect does three things:
//   - flushes the queue;
//   - marks every still-outstanding response as stale, so it is discarded;
//   - restarts fetching at the redirect target.
//
// Parameters
//   RESET_PC  first fetch address after reset
//   DEPTH     number of prefetch queue entries
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-low reset
//   imem_req        fetch request valid
//   imem_addr       fetch byte address
//   imem_ready      memory accepts the request this cycle
//   imem_valid      in-order response valid
//   imem_rdata      response instruction word
//   redirect_valid  branch/jump redirect strobe
//   redirect_pc     redirect target address
//   halt            stop issuing new fetches
//   stall           IF/ID register is not writing this cycle
//   instr_valid     instr_out/pc_out hold a valid instruction
//   instr_out       instruction at the queue head
//   pc_out          address of instr_out

module if_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_valid,
    input  logic [63:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        halt,
    input  logic        stall,
    output logic        instr_valid,
    output logic [63:0] instr_out,
    output logic [63:0] pc_out
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {BOOT, FETCH, HALT} state_t;

    state_t state, state_next;

    logic [63:0]      fetch_pc;
    logic [63:0]      resp_pc;
    logic [CNT_W-1:0] pending;
    logic [CNT_W-1:0] drop;
    logic [CNT_W-1:0] q_count;
    logic [PTR_W-1:0] q_head;
    logic [PTR_W-1:0] q_tail;
    logic [63:0]      q_instr [DEPTH];
    logic [63:0]      q_pc    [DEPTH];

    logic credit_ok;
    logic issue;
    logic push;
    logic pop;

    // Pointers wrap explicitly, so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Every in-flight response must already own a queue slot.
    assign credit_ok = ({1'b0, pending} + {1'b0, q_count}) < (CNT_W + 1)'(DEPTH);
    assign issue     = imem_req && imem_ready;

    // A response is pushed only if it is not stale and no redirect is
    // flushing the queue in the same cycle.
    assign push = imem_valid && (drop == '0) && !redirect_valid;
    assign pop  = instr_valid && !stall && !redirect_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = FETCH;
            FETCH:   if (halt) state_next = HALT;
            HALT:    if (!halt) state_next = FETCH;
            default: state_next = BOOT;
        endcase
    end

    // The reset input gates the outputs so they read zero while reset is held.
    always_comb begin
        imem_req    = reset && (state == FETCH) && !halt && !redirect_valid && credit_ok;
        imem_addr   = fetch_pc;
        instr_valid = reset && (q_count != '0);
        instr_out   = '0;
        pc_out      = '0;
        if (instr_valid) begin
            instr_out = q_instr[q_head];
            pc_out    = q_pc[q_head];
        end
    end

    // resp_pc is the address of the next non-stale response. Responses come
    // back in request order, and non-stale requests were issued sequentially
    // from the last redirect target (or RESET_PC).
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            pending  <= '0;
            drop     <= '0;
            q_head   <= '0;
            q_tail   <= '0;
            q_count  <= '0;
        end else begin
            pending <= pending + CNT_W'(issue) - CNT_W'(imem_valid);
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                drop     <= pending - CNT_W'(imem_valid);
                q_head   <= '0;
                q_tail   <= '0;
                q_count  <= '0;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + 64'd8;
                end
                if (imem_valid && (drop != '0)) begin
                    drop <= drop - CNT_W'(1);
                end
                if (push) begin
                    q_tail  <= next_ptr(q_tail);
                    resp_pc <= resp_pc + 64'd8;
                end
                if (pop) begin
                    q_head <= next_ptr(q_head);
                end
                case ({push, pop})
                    2'b10:   q_count <= q_count + CNT_W'(1);
                    2'b01:   q_count <= q_count - CNT_W'(1);
                    default: q_count <= q_count;
                endcase
            end
        end
    end

    // Queue storage needs no reset; the outputs are masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            q_instr[q_tail] <= imem_rdata;
            q_pc[q_tail]    <= resp_pc;
        end
    end

    // The credit rule makes both of these conditions unreachable.
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(push && (q_count == CNT_W'(DEPTH))));
            assert (!(imem_valid && (pending == '0)));
        end
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h0, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the number of prefetch queue entries.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: the reset, which SHALL be synchronous and active-low.
REQ-005 Port imem_req, output, 1 bit: fetch request valid.
REQ-006 Port imem_addr, output, 64 bits: fetch byte address.
REQ-007 Port imem_ready, input, 1 bit: memory accepts the request this cycle.
REQ-008 Port imem_valid, input, 1 bit: response valid; responses return in request order.
REQ-009 Port imem_rdata, input, 64 bits: response instruction word.
REQ-010 Port redirect_valid, input, 1 bit: branch/jump redirect strobe.
REQ-011 Port redirect_pc, input, 64 bits: redirect target address.
REQ-012 Port halt, input, 1 bit: stop issuing new fetches.
REQ-013 Port stall, input, 1 bit: downstream IF/ID register is not writing this cycle.
REQ-014 Port instr_valid, output, 1 bit: instr_out/pc_out hold a valid instruction.
REQ-015 Port instr_out, output, 64 bits: instruction presented to the IF/ID register's instruction_in.
REQ-016 Port pc_out, output, 64 bits: address of instr_out.

Function
REQ-017 The FSM SHALL have states BOOT, FETCH and HALT: BOOT->FETCH unconditionally after one cycle; FETCH->HALT when halt=1; HALT->FETCH when halt=0.
REQ-018 Counters SHALL be: fetch_pc (64b), pending (in-flight requests, 0..DEPTH) and drop (in-flight responses to discard, 0..pending).
REQ-019 imem_req SHALL be 1 only in FETCH with halt=0, redirect_valid=0 and pending+queue_count < DEPTH (credit rule: every response always has a queue slot).
REQ-020 imem_addr SHALL equal fetch_pc; a request SHALL issue when imem_req&&imem_ready, then fetch_pc += 8 modulo 2^64 (0xFFFF_FFFF_FFFF_FFF8 wraps to 0) and pending increments.
REQ-021 Each imem_valid SHALL decrement pending; if drop>0 the response SHALL be discarded and drop decremented, else {imem_rdata, its address} SHALL be pushed to the queue.
REQ-022 Issue and response in the same cycle SHALL leave pending unchanged.
REQ-023 instr_valid SHALL be 1 iff the queue is non-empty; instr_out/pc_out SHALL show the head entry combinationally from registers.
REQ-024 The head SHALL be popped when instr_valid&&!stall; a push to an empty queue SHALL appear on instr_valid the next cycle (response-to-output latency 1 cycle).
REQ-025 Simultaneous push and pop SHALL keep queue_count unchanged; queue pointers SHALL wrap modulo DEPTH.
REQ-026 On redirect_valid=1: the queue SHALL be flushed, fetch_pc <= redirect_pc, drop <= pending after this cycle's response decrement, no request issued, any same-cycle response discarded.
REQ-027 redirect_valid SHALL override stall, halt and pop in the same cycle; instr_valid SHALL be 0 on the following cycle.
REQ-028 In HALT, in-flight responses SHALL still be accepted and the queue SHALL drain normally.
REQ-029 A push to a full queue or a response with pending=0 SHALL be impossible by construction and flagged by a simulation assertion.

Reset
REQ-030 While reset=0 at a clock edge: state<=BOOT, fetch_pc<=RESET_PC, pending<=0, drop<=0, queue empty.
REQ-031 During and immediately after reset: imem_req=0, instr_valid=0, instr_out=0, pc_out=0.
REQ-032 Reset mid-transaction SHALL abandon all in-flight requests; the memory model SHALL be reset by the same signal.

Verification
REQ-033 Reset release, imem_ready=1, 1-cycle-latency memory, stall=0 -> addresses 0x0,0x8,0x10 issued; pc_out sequence 0x0,0x8,0x10 with matching data.
REQ-034 stall=1 held 5 cycles with DEPTH=2 -> imem_req drops after 2 credits used; instr_out stable; no response lost after release.
REQ-035 redirect to 0x1000 while pending=2 -> both stale responses discarded; next instr_valid carries pc_out=0x1000.
REQ-036 fetch_pc=0xFFFF_FFFF_FFFF_FFF8 -> next imem_addr=0x0.
REQ-037 halt=1 with pending=1 -> no new requests; pending response delivered; halt=0 resumes at the next sequential address.
REQ-038 reset=0 asserted with pending=2 and queue full -> next cycle outputs zero, fetch restarts at RESET_PC.
